// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a ready/valid imem handshake and feeds IF/ID.
// Optional macro PC_KERNEL_PROTECT_EN keeps user-mode fetches from redirecting into kernel space.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h8000_0000,
    parameter logic [31:0] ILLOP_VEC = 32'h8000_0004,
    parameter logic [31:0] XADR_VEC  = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        illop,
    input  logic        xadr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_valid,
    output logic        redirect
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] pend_addr_q, pend_addr_d;

    logic        take;
    logic [31:0] target;
    logic [31:0] jr_tgt, jump_tgt, br_tgt;

`ifdef PC_KERNEL_PROTECT_EN
    // Bit 31 is the kernel-mode bit; only exception vectors may set it from user mode.
    assign jr_tgt   = {pc_q[31] & jr_target[31], jr_target[30:0]};
    assign jump_tgt = {pc_q[31], jump_target[30:0]};
    assign br_tgt   = {pc_q[31], branch_target[30:0]};
`else
    assign jr_tgt   = jr_target;
    assign jump_tgt = jump_target;
    assign br_tgt   = branch_target;
`endif

    assign take     = illop | xadr | jr | jump | branch_taken;
    assign redirect = (jr | jump | branch_taken) & ~illop & ~xadr;

    always_comb begin
        target = br_tgt;
        if (illop) begin
            target = ILLOP_VEC;
        end else if (xadr) begin
            target = XADR_VEC;
        end else if (jr) begin
            target = jr_tgt;
        end else if (jump) begin
            target = jump_tgt;
        end
    end

    always_comb begin
        imem_req       = 1'b0;
        imem_addr      = pc_q;
        if_valid       = 1'b0;
        if_instruction = 32'h0;
        if_pc          = pc_q;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if_valid = imem_ready & ~stall & ~take;
                if (imem_ready && !stall && !take) begin
                    if_instruction = imem_rdata;
                end
            end
            HOLD: begin
                if_valid       = 1'b1;
                if_instruction = hold_buf_q;
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = pend_addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_buf_d  = hold_buf_q;
        pend_addr_d = pend_addr_q;
        if (take) begin
            pc_d = target;
        end
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (take) begin
                    // The in-flight request must still complete at its own address.
                    if (!imem_ready) begin
                        pend_addr_d = pc_q;
                        state_d     = DISCARD;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        hold_buf_d = imem_rdata;
                        state_d    = HOLD;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            HOLD: begin
                if (take) begin
                    state_d = FETCH;
                end else if (!stall) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            hold_buf_q  <= 32'h0;
            pend_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_buf_q  <= hold_buf_d;
            pend_addr_q <= pend_addr_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed vector table, reset-in-DISCARD sequence,
// then random stimulus checked against a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] ILL_PC = 32'h8000_0004;
    localparam logic [31:0] XV_PC  = 32'h8000_0008;
`ifdef PC_KERNEL_PROTECT_EN
    localparam logic [31:0] KJ = 32'h0000_0200;
`else
    localparam logic [31:0] KJ = 32'h8000_0200;
`endif

    // control word: {illop, xadr, jr, jump, branch, stall, ready}
    localparam logic [6:0] C_RDY = 7'b0000001;
    localparam logic [6:0] C_STL = 7'b0000010;
    localparam logic [6:0] C_BR  = 7'b0000100;
    localparam logic [6:0] C_JMP = 7'b0001000;
    localparam logic [6:0] C_JR  = 7'b0010000;
    localparam logic [6:0] C_ILL = 7'b1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, jr = 1'b0;
    logic        illop = 1'b0, xadr = 1'b0, imem_ready = 1'b0;
    logic [31:0] branch_target = 32'h0, jump_target = 32'h0, jr_target = 32'h0;
    logic        imem_req, if_valid, redirect;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_instruction;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .jump           (jump),
        .jump_target    (jump_target),
        .jr             (jr),
        .jr_target      (jr_target),
        .illop          (illop),
        .xadr           (xadr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .redirect       (redirect)
    );

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        redir;
    } vec_t;

    vec_t vt[22];

    function automatic vec_t mk(input logic [6:0] c, input logic [31:0] t, input logic rq,
                                input logic [31:0] ad, input logic v, input logic [31:0] pc,
                                input logic rd);
        vec_t r;
        r.ctrl  = c;
        r.tgt   = t;
        r.req   = rq;
        r.addr  = ad;
        r.valid = v;
        r.instr = v ? mem_word(ad) : 32'h0;
        r.pc    = pc;
        r.redir = rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [6:0] c, input logic [31:0] bt, input logic [31:0] jt,
                         input logic [31:0] jrt);
        {illop, xadr, jr, jump, branch_taken, stall, imem_ready} = c;
        branch_target = bt;
        jump_target   = jt;
        jr_target     = jrt;
    endtask

    task automatic check_outs(input string tag, input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] ins, input logic [31:0] pc,
                              input logic rd);
        check({tag, "_req"}, {31'h0, imem_req}, {31'h0, rq});
        if (rq) check({tag, "_addr"}, imem_addr, ad);
        check({tag, "_valid"}, {31'h0, if_valid}, {31'h0, v});
        check({tag, "_instr"}, if_instruction, ins);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_redirect"}, {31'h0, redirect}, {31'h0, rd});
    endtask

    // Reference model: fetch progress described as "started", "a buffered word
    // waiting to be presented" and "an abandoned request still outstanding".
    bit          m_started, m_buf_valid, m_pend_valid;
    logic [31:0] m_buf, m_pend_addr, m_pc;

    function automatic logic [31:0] guard(input logic [31:0] cur, input logic [31:0] t,
                                          input bit is_jr);
        logic [31:0] r;
        r = t;
`ifdef PC_KERNEL_PROTECT_EN
        if (!cur[31]) r[31] = 1'b0;
        else if (!is_jr) r[31] = 1'b1;
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_started = 0; m_buf_valid = 0; m_pend_valid = 0;
        m_buf = 32'h0; m_pend_addr = 32'h0; m_pc = RST_PC;
    endtask

    initial begin
        logic        e_req, e_valid, e_redir, tk;
        logic [31:0] e_addr, e_instr, tgt, old_pc;
        logic [6:0]  c;
        logic [31:0] bt, jt, jrt;

        vt[0]  = mk(C_RDY,         32'h0,         0, 32'h0,         0, RST_PC,        0);
        vt[1]  = mk(C_RDY,         32'h0,         1, 32'h8000_0000, 1, 32'h8000_0000, 0);
        vt[2]  = mk(C_RDY,         32'h0,         1, 32'h8000_0004, 1, 32'h8000_0004, 0);
        vt[3]  = mk(C_RDY,         32'h0,         1, 32'h8000_0008, 1, 32'h8000_0008, 0);
        vt[4]  = mk(C_RDY,         32'h0,         1, 32'h8000_000C, 1, 32'h8000_000C, 0);
        vt[5]  = mk(C_RDY | C_STL, 32'h0,         1, 32'h8000_0010, 0, 32'h8000_0010, 0);
        vt[6]  = mk(C_RDY | C_STL, 32'h0,         0, 32'h8000_0010, 1, 32'h8000_0010, 0);
        vt[7]  = mk(C_STL,         32'h0,         0, 32'h8000_0010, 1, 32'h8000_0010, 0);
        vt[8]  = mk(7'h0,          32'h0,         0, 32'h8000_0010, 1, 32'h8000_0010, 0);
        vt[9]  = mk(C_RDY,         32'h0,         1, 32'h8000_0014, 1, 32'h8000_0014, 0);
        vt[10] = mk(C_RDY,         32'h0,         1, 32'h8000_0018, 1, 32'h8000_0018, 0);
        vt[11] = mk(C_RDY,         32'h0,         1, 32'h8000_001C, 1, 32'h8000_001C, 0);
        vt[12] = mk(C_BR,          32'h8000_0100, 1, 32'h8000_0020, 0, 32'h8000_0020, 1);
        vt[13] = mk(7'h0,          32'h0,         1, 32'h8000_0020, 0, 32'h8000_0100, 0);
        vt[14] = mk(7'h0,          32'h0,         1, 32'h8000_0020, 0, 32'h8000_0100, 0);
        vt[15] = mk(C_RDY,         32'h0,         1, 32'h8000_0020, 0, 32'h8000_0100, 0);
        vt[16] = mk(C_RDY,         32'h0,         1, 32'h8000_0100, 1, 32'h8000_0100, 0);
        vt[17] = mk(C_RDY | C_ILL | C_JR | C_STL, 32'h1234_5678,
                                                  1, 32'h8000_0104, 0, 32'h8000_0104, 0);
        vt[18] = mk(C_RDY,         32'h0,         1, ILL_PC,        1, ILL_PC,        0);
        vt[19] = mk(C_RDY | C_JR,  32'h0000_0040, 1, 32'h8000_0008, 0, 32'h8000_0008, 1);
        vt[20] = mk(C_RDY | C_JMP, 32'h8000_0200, 1, 32'h0000_0040, 0, 32'h0000_0040, 1);
        vt[21] = mk(C_RDY,         32'h0,         1, KJ,            1, KJ,            0);

        // Reset held: check reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outs("reset", 0, 32'h0, 0, 32'h0, RST_PC, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            apply(vt[i].ctrl, vt[i].tgt, vt[i].tgt, vt[i].tgt);
            @(negedge clk);
            $display("vec %0d: req=%0b addr=%h valid=%0b instr=%h pc=%h redirect=%0b",
                     i, imem_req, imem_addr, if_valid, if_instruction, if_pc, redirect);
            check_outs($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].valid,
                       vt[i].instr, vt[i].pc, vt[i].redir);
            @(posedge clk); #1;
        end

        // Branch with memory not ready -> DISCARD, then reset asserted mid-transaction.
        apply(C_BR, 32'h8000_0300, 32'h0, 32'h0);
        @(negedge clk);
        check_outs("disc_enter", 1, KJ + 32'd4, 0, 32'h0, KJ + 32'd4, 1);
        @(posedge clk); #1;
        apply(7'h0, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        check_outs("disc_wait", 1, KJ + 32'd4, 0, 32'h0, 32'h8000_0300, 0);
        #2 reset = 1'b0;
        #1;
        $display("reset in DISCARD: req=%0b valid=%0b pc=%h", imem_req, if_valid, if_pc);
        check_outs("async_rst", 0, 32'h0, 0, 32'h0, RST_PC, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            c = 7'h0;
            c[0] = ($urandom_range(0, 2) != 0);
            c[1] = ($urandom_range(0, 3) == 0);
            c[2] = ($urandom_range(0, 7) == 0);
            c[3] = ($urandom_range(0, 11) == 0);
            c[4] = ($urandom_range(0, 11) == 0);
            c[5] = ($urandom_range(0, 23) == 0);
            c[6] = ($urandom_range(0, 23) == 0);
            bt = $urandom; jt = $urandom; jrt = $urandom;
            apply(c, bt, jt, jrt);
            @(negedge clk);

            tk      = illop | xadr | jr | jump | branch_taken;
            e_redir = (jr | jump | branch_taken) & !illop & !xadr;
            e_req   = 0; e_addr = m_pc; e_valid = 0; e_instr = 32'h0;
            if (!m_started) begin
                e_req = 0;
            end else if (m_buf_valid) begin
                e_valid = 1; e_instr = m_buf;
            end else if (m_pend_valid) begin
                e_req = 1; e_addr = m_pend_addr;
            end else begin
                e_req = 1;
                e_valid = imem_ready & !stall & !tk;
                if (e_valid) e_instr = mem_word(m_pc);
            end
            check_outs($sformatf("rnd%0d", n), e_req, e_addr, e_valid, e_instr, m_pc, e_redir);
            if (e_valid)
                $display("rnd %0d: delivered pc=%h instr=%h", n, if_pc, if_instruction);

            if (illop)             tgt = ILL_PC;
            else if (xadr)         tgt = XV_PC;
            else if (jr)           tgt = guard(m_pc, jrt, 1);
            else if (jump)         tgt = guard(m_pc, jt, 0);
            else                   tgt = guard(m_pc, bt, 0);
            old_pc = m_pc;
            if (!m_started) begin
                m_started = 1;
                if (tk) m_pc = tgt;
            end else if (m_buf_valid) begin
                if (tk) begin
                    m_buf_valid = 0; m_pc = tgt;
                end else if (!stall) begin
                    m_buf_valid = 0; m_pc = old_pc + 32'd4;
                end
            end else if (m_pend_valid) begin
                if (tk) m_pc = tgt;
                if (imem_ready) m_pend_valid = 0;
            end else begin
                if (tk) begin
                    m_pc = tgt;
                    if (!imem_ready) begin
                        m_pend_valid = 1; m_pend_addr = old_pc;
                    end
                end else if (imem_ready) begin
                    if (stall) begin
                        m_buf_valid = 1; m_buf = mem_word(old_pc);
                    end else begin
                        m_pc = old_pc + 32'd4;
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
